// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: pixel/line counters, sync, display enable and strobes.
// Define VTG_SHADOW_EN to latch all timing inputs at frame boundaries instead of using them live.
module video_timing_gen #(
  parameter int CW = 11
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          enable,
  input  logic [CW-1:0] h_total,
  input  logic [CW-1:0] v_total,
  input  logic [CW-1:0] h_disp_start,
  input  logic [CW-1:0] h_disp_end,
  input  logic [CW-1:0] v_disp_start,
  input  logic [CW-1:0] v_disp_end,
  input  logic [CW-1:0] h_sync_start,
  input  logic [CW-1:0] h_sync_end,
  input  logic [CW-1:0] v_sync_start,
  input  logic [CW-1:0] v_sync_end,
  output logic [CW-1:0] px,
  output logic [CW-1:0] py,
  output logic          hsync,
  output logic          vsync,
  output logic          disp_en,
  output logic          line_start,
  output logic          frame_start,
  output logic [CW-1:0] xstart,
  output logic [CW-1:0] xend,
  output logic [CW-1:0] ystart,
  output logic [CW-1:0] yend
);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [CW-1:0] h_total;
    logic [CW-1:0] v_total;
    logic [CW-1:0] h_disp_start;
    logic [CW-1:0] h_disp_end;
    logic [CW-1:0] v_disp_start;
    logic [CW-1:0] v_disp_end;
    logic [CW-1:0] h_sync_start;
    logic [CW-1:0] h_sync_end;
    logic [CW-1:0] v_sync_start;
    logic [CW-1:0] v_sync_end;
  } timing_t;

  state_t        state;
  timing_t       live_t;
  timing_t       dec_t;
  logic [CW-1:0] wrap_h;
  logic [CW-1:0] wrap_v;
  logic [CW-1:0] nx;
  logic [CW-1:0] ny;

  assign live_t = '{h_total: h_total, v_total: v_total,
                    h_disp_start: h_disp_start, h_disp_end: h_disp_end,
                    v_disp_start: v_disp_start, v_disp_end: v_disp_end,
                    h_sync_start: h_sync_start, h_sync_end: h_sync_end,
                    v_sync_start: v_sync_start, v_sync_end: v_sync_end};

`ifdef VTG_SHADOW_EN
  timing_t shadow_t;
  logic    capture;

  // Capture happens on the edge that presents (0,0); that pixel already decodes with the new values.
  assign capture = enable && (nx == '0) && (ny == '0);
  assign dec_t   = capture ? live_t : shadow_t;
  assign wrap_h  = shadow_t.h_total;
  assign wrap_v  = shadow_t.v_total;
  assign xstart  = shadow_t.h_disp_start;
  assign xend    = shadow_t.h_disp_end;
  assign ystart  = shadow_t.v_disp_start;
  assign yend    = shadow_t.v_disp_end;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      shadow_t <= '0;
    end else if (capture) begin
      shadow_t <= live_t;
    end
  end
`else
  assign dec_t  = live_t;
  assign wrap_h = h_total;
  assign wrap_v = v_total;
  assign xstart = h_disp_start;
  assign xend   = h_disp_end;
  assign ystart = v_disp_start;
  assign yend   = v_disp_end;
`endif

  // Next counter values; >= lets a total reprogrammed below the count wrap immediately.
  always_comb begin
    nx = '0;
    ny = '0;
    if (state == RUN && enable) begin
      if (px >= wrap_h) begin
        ny = (py >= wrap_v) ? '0 : py + CW'(1);
      end else begin
        nx = px + CW'(1);
        ny = py;
      end
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      px          <= '0;
      py          <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      disp_en     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      px <= nx;
      py <= ny;
      if (enable) begin
        state       <= RUN;
        hsync       <= (nx >= dec_t.h_sync_start) && (nx < dec_t.h_sync_end);
        vsync       <= (ny >= dec_t.v_sync_start) && (ny < dec_t.v_sync_end);
        disp_en     <= (nx > dec_t.h_disp_start) && (nx <= dec_t.h_disp_end) &&
                       (ny > dec_t.v_disp_start) && (ny <= dec_t.v_disp_end);
        line_start  <= (nx == '0);
        frame_start <= (nx == '0) && (ny == '0);
      end else begin
        state       <= IDLE;
        hsync       <= 1'b0;
        vsync       <= 1'b0;
        disp_en     <= 1'b0;
        line_start  <= 1'b0;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen: directed raster scenarios plus randomized reprogramming,
// checked against a cycle-level reference model of the raster rules (honours VTG_SHADOW_EN).
module tb_video_timing_gen;
  localparam int CW = 11;

  logic          pclk = 1'b0;
  logic          reset;
  logic          enable;
  logic [CW-1:0] h_total, v_total, h_disp_start, h_disp_end, v_disp_start, v_disp_end;
  logic [CW-1:0] h_sync_start, h_sync_end, v_sync_start, v_sync_end;
  logic [CW-1:0] px, py, xstart, xend, ystart, yend;
  logic          hsync, vsync, disp_en, line_start, frame_start;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int ht, vt, hds, hde, vds, vde, hss, hse, vss, vse;
  } tim_t;

  tim_t sh;
  bit   m_run;
  int   mx, my;
  int   e_hs, e_vs, e_de, e_ls, e_fs, e_xs, e_xe, e_ys, e_ye;

  video_timing_gen #(.CW(CW)) dut (
    .pclk(pclk), .reset(reset), .enable(enable),
    .h_total(h_total), .v_total(v_total),
    .h_disp_start(h_disp_start), .h_disp_end(h_disp_end),
    .v_disp_start(v_disp_start), .v_disp_end(v_disp_end),
    .h_sync_start(h_sync_start), .h_sync_end(h_sync_end),
    .v_sync_start(v_sync_start), .v_sync_end(v_sync_end),
    .px(px), .py(py), .hsync(hsync), .vsync(vsync), .disp_en(disp_en),
    .line_start(line_start), .frame_start(frame_start),
    .xstart(xstart), .xend(xend), .ystart(ystart), .yend(yend)
  );

  always #5 pclk = ~pclk;

  function automatic tim_t liveTiming();
    tim_t t;
    t.ht  = int'(h_total);      t.vt  = int'(v_total);
    t.hds = int'(h_disp_start); t.hde = int'(h_disp_end);
    t.vds = int'(v_disp_start); t.vde = int'(v_disp_end);
    t.hss = int'(h_sync_start); t.hse = int'(h_sync_end);
    t.vss = int'(v_sync_start); t.vse = int'(v_sync_end);
    return t;
  endfunction

  // Expected outputs follow from the raster position and the timing set in force.
  function automatic void evalOutputs();
    tim_t d;
`ifdef VTG_SHADOW_EN
    d = sh;
`else
    d = liveTiming();
`endif
    e_xs = d.hds; e_xe = d.hde; e_ys = d.vds; e_ye = d.vde;
    if (m_run) begin
      e_hs = int'(mx >= d.hss && mx < d.hse);
      e_vs = int'(my >= d.vss && my < d.vse);
      e_de = int'(mx > d.hds && mx <= d.hde && my > d.vds && my <= d.vde);
      e_ls = int'(mx == 0);
      e_fs = int'(mx == 0 && my == 0);
    end else begin
      e_hs = 0; e_vs = 0; e_de = 0; e_ls = 0; e_fs = 0;
    end
  endfunction

  function automatic void modelReset();
    m_run = 1'b0; mx = 0; my = 0;
    sh = '{default: 0};
    evalOutputs();
  endfunction

  function automatic void modelStep();
    tim_t lv = liveTiming();
    tim_t w;
    if (!m_run) begin
      if (enable) begin
        m_run = 1'b1; mx = 0; my = 0; sh = lv;
      end
    end else if (!enable) begin
      m_run = 1'b0; mx = 0; my = 0;
    end else begin
`ifdef VTG_SHADOW_EN
      w = sh;
`else
      w = lv;
`endif
      if (mx >= w.ht) begin
        mx = 0;
        my = (my >= w.vt) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
      if (mx == 0 && my == 0) sh = lv;
    end
    evalOutputs();
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    chk("px", 32'(px), 32'(mx));
    chk("py", 32'(py), 32'(my));
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("disp_en", 32'(disp_en), 32'(e_de));
    chk("line_start", 32'(line_start), 32'(e_ls));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("xstart", 32'(xstart), 32'(e_xs));
    chk("xend", 32'(xend), 32'(e_xe));
    chk("ystart", 32'(ystart), 32'(e_ys));
    chk("yend", 32'(yend), 32'(e_ye));
  endtask

  // One clock: advance the model with the inputs the DUT is about to sample, then compare.
  task automatic applyStimulus();
    if (reset) modelReset();
    else       modelStep();
    @(posedge pclk);
    #1;
    checkOutput();
  endtask

  task automatic setBasic();
    h_total = 9;      v_total = 4;
    h_disp_start = 1; h_disp_end = 7;
    v_disp_start = 0; v_disp_end = 2;
    h_sync_start = 8; h_sync_end = 9;
    v_sync_start = 3; v_sync_end = 4;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    enable = 1'b0;
    setBasic();
    modelReset();
    @(posedge pclk);
    #1;
    checkOutput();

    $display("[TB] idle after reset release");
    reset = 1'b0;
    repeat (3) applyStimulus();

    $display("[TB] basic raster");
    enable = 1'b1;
    applyStimulus();
    chk("first_frame_start", 32'(frame_start), 32'd1);
    chk("first_line_start", 32'(line_start), 32'd1);
    repeat (49) applyStimulus();
    chk("frame_49_no_strobe", 32'(frame_start), 32'd0);
    applyStimulus();
    chk("frame_period_50", 32'(frame_start), 32'd1);
    chk("frame_period_px", 32'(px), 32'd0);

    $display("[TB] reprogram h_total at px=8");
    n = 0;
    while (!(mx == 8 && my == 0) && n < 100) begin applyStimulus(); n++; end
    chk("reach_px8", 32'(n < 100), 32'd1);
    h_total = 5;
    applyStimulus();
`ifdef VTG_SHADOW_EN
    chk("reprog_px", 32'(px), 32'd9);
    chk("reprog_py", 32'(py), 32'd0);
`else
    chk("reprog_px", 32'(px), 32'd0);
    chk("reprog_py", 32'(py), 32'd1);
`endif
    repeat (80) applyStimulus();

    $display("[TB] disable mid-frame");
    n = 0;
    while (!(mx == 4 && my == 2) && n < 200) begin applyStimulus(); n++; end
    chk("reach_px4_py2", 32'(n < 200), 32'd1);
    enable = 1'b0;
    applyStimulus();
    chk("disable_px", 32'(px), 32'd0);
    chk("disable_ls", 32'(line_start), 32'd0);
    applyStimulus();
    enable = 1'b1;
    applyStimulus();
    chk("reenable_fs", 32'(frame_start), 32'd1);

    $display("[TB] degenerate h_total=0");
    enable = 1'b0;
    applyStimulus();
    h_total = 0;
    v_total = 3;
    enable = 1'b1;
    applyStimulus();
    repeat (3) applyStimulus();
    chk("degen_py3", 32'(py), 32'd3);
    chk("degen_ls", 32'(line_start), 32'd1);
    applyStimulus();
    chk("degen_fs4", 32'(frame_start), 32'd1);
    repeat (8) applyStimulus();

    $display("[TB] async reset mid-line");
    setBasic();
    repeat (13) applyStimulus();
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput();
    chk("async_px", 32'(px), 32'd0);
    enable = 1'b0;
    reset = 1'b0;
    repeat (3) applyStimulus();

    $display("[TB] randomized reprogramming");
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 9))
          0: h_total      = CW'($urandom_range(0, 15));
          1: v_total      = CW'($urandom_range(0, 7));
          2: h_disp_start = CW'($urandom_range(0, 15));
          3: h_disp_end   = CW'($urandom_range(0, 15));
          4: v_disp_start = CW'($urandom_range(0, 7));
          5: v_disp_end   = CW'($urandom_range(0, 7));
          6: h_sync_start = CW'($urandom_range(0, 15));
          7: h_sync_end   = CW'($urandom_range(0, 15));
          8: v_sync_start = CW'($urandom_range(0, 7));
          default: v_sync_end = CW'($urandom_range(0, 7));
        endcase
      end
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Programmable raster timing generator in the pixel clock domain. Produces pixel/line counters, sync, display-enable and frame/line strobes. Its px/py and display-window outputs directly feed the test-pattern stage and the pixel pipeline. Timing values come from the register block; with shadowing compiled in, they take effect only at frame boundaries.

Parameters:
CW, 11, counter and timing-value width in bits

Ports:
pclk  in  1  pixel clock
reset  in  1  asynchronous reset, active-high
enable  in  1  run raster when 1; idle when 0
h_total, v_total  in  CW each  last px / last py index of a line / frame
h_disp_start, h_disp_end  in  CW each  horizontal display window, active for h_disp_start < px <= h_disp_end
v_disp_start, v_disp_end  in  CW each  vertical display window, same rule on py
h_sync_start, h_sync_end  in  CW each  hsync asserted for h_sync_start <= px < h_sync_end
v_sync_start, v_sync_end  in  CW each  vsync asserted for v_sync_start <= py < v_sync_end
px, py  out  CW each  current pixel / line index
hsync, vsync  out  1 each  active-high sync
disp_en  out  1  horizontal AND vertical window active
line_start  out  1  one-cycle pulse when px==0
frame_start  out  1  one-cycle pulse when px==0 and py==0
xstart, xend, ystart, yend  out  CW each  effective h_disp_start / h_disp_end / v_disp_start / v_disp_end for downstream consumers

Behaviour:
- Clock and reset: one clock, pclk. reset is asynchronous and active-high.
- Reset state: IDLE. All outputs and shadow registers are 0.
- FSM states: IDLE and RUN.
- IDLE:
  - px=py=0; hsync, vsync, disp_en, line_start and frame_start are all 0.
  - On the first edge with enable=1: go to RUN, keep px=py=0, assert frame_start=1 and line_start=1, decode sync/disp_en for (0,0).
- RUN, every edge:
  - If px >= h_total: px<=0, and py<=(py >= v_total) ? 0 : py+1.
  - Otherwise px<=px+1.
  - The >= comparison makes reprogramming total below the current count wrap on the next edge; no runaway.
- RUN with enable=0 sampled: next edge returns to IDLE and outputs are zeroed. There is no wait for end of frame.
- Output alignment:
  - hsync, vsync, disp_en, line_start and frame_start are registered.
  - They are decoded from the next-state counter values, so they describe the px/py presented in the same cycle.
  - Zero relative latency between counters and decodes.
- Degenerate timings:
  - h_total=0: px stays 0, py advances every cycle, line_start stays high.
  - Start >= end for a window or sync: that signal is never asserted.
- xstart/xend/ystart/yend always equal the values the decoders are using, whether shadow or live.
- Counters are CW bits; no arithmetic exceeds CW (totals < 2^CW).

Optional Feature:
Macro: VTG_SHADOW_EN
- Defined:
  - All ten timing inputs are captured into shadow registers on the IDLE->RUN edge and on every edge producing px=0,py=0 in RUN.
  - Decodes, wrap points and xstart..yend use the shadow copies only.
  - Mid-frame input changes have no effect until the next frame.
- Not defined: decodes use the live inputs directly, and no shadow registers exist.

Test Plan:
- Reset and idle: assert reset with enable=1 mid-line -> all outputs 0 immediately (asynchronously). Release with enable=0 -> outputs stay 0.
- Basic raster:
  - Setup: h_total=9, h_disp 1..7, h_sync 8..9, v_total=4, v_disp 0..2, v_sync 3..4, enable rises.
  - Expect frame_start on the first edge; px sequence 0..9,0.
  - disp_en high for px 2..7 on py 1..2 only; hsync high at px=8 only; vsync high on py=3.
  - frame_start again exactly 50 cycles after the first.
- Wrap on reprogram: at px=8, change h_total from 9 to 5 (macro off) -> next px=0 and py increments.
- Same reprogram with VTG_SHADOW_EN -> line length stays 10 until the next frame_start; from then, 6-cycle lines.
- Disable mid-frame: drop enable at px=4,py=2 -> next edge px=py=0 with all strobes 0. Re-enable -> frame_start pulses on the first enabled edge.
- Degenerate: h_total=0, v_total=3 -> px constant 0, py cycles 0,1,2,3,0, line_start constant 1, frame_start every 4 cycles.
